// File: rtl/shader_pkg.sv
// Types and constants shared by the shader sequencer and the shader instruction memory.
package shader_pkg;

  localparam int unsigned INSTR_W = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_LOAD
  } seq_state_t;

  // Program the memory holds after reset; slots past the table read as NOP (0x00).
  function automatic logic [INSTR_W-1:0] default_instr(input int unsigned idx);
    case (idx)
      0:       return 8'h10;
      1:       return 8'h15;
      2:       return 8'h74;
      3:       return 8'h20;
      4:       return 8'h31;
      5:       return 8'h42;
      6:       return 8'h53;
      7:       return 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/shader_sequencer.sv
// Sequences the circular shader instruction memory: one full rotation per pixel,
// and byte-wide program loading between pixels.
module shader_sequencer
  import shader_pkg::*;
#(
  parameter int unsigned  NUM_INSTR = 8,
  localparam int unsigned PC_W      = $clog2(NUM_INSTR)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               prog_req_i,
  input  logic               prog_valid_i,
  input  logic [INSTR_W-1:0] prog_data_i,
  output logic               prog_ready_o,
  output logic               prog_done_o,
  output logic               shift_o,
  output logic               load_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               exec_valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               pixel_done_o,
  output logic               busy_o,
  output logic               start_miss_o
);

  localparam logic [PC_W-1:0] LAST = PC_W'(NUM_INSTR - 1);

  seq_state_t      state_q, state_d;
  // Serves as pc in RUN and as the accepted-byte count in LOAD.
  logic [PC_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prog_ready_o = 1'b0;
    prog_done_o  = 1'b0;
    shift_o      = 1'b0;
    load_o       = 1'b0;
    instr_o      = '0;
    exec_valid_o = 1'b0;
    pc_o         = '0;
    pixel_done_o = 1'b0;
    start_miss_o = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          state_d = SEQ_RUN;
          cnt_d   = '0;
        end else if (prog_req_i) begin
          state_d = SEQ_LOAD;
          cnt_d   = '0;
        end
      end

      SEQ_RUN: begin
        exec_valid_o = 1'b1;
        shift_o      = 1'b1;
        pc_o         = cnt_q;
        if (cnt_q == LAST) begin
          // A start on the final instruction chains the next pixel with no gap.
          pixel_done_o = 1'b1;
          cnt_d        = '0;
          if (!start_i) state_d = SEQ_IDLE;
        end else begin
          cnt_d        = cnt_q + 1'b1;
          start_miss_o = start_i;
        end
      end

      SEQ_LOAD: begin
        prog_ready_o = 1'b1;
        start_miss_o = start_i;
        if (prog_valid_i) begin
          shift_o = 1'b1;
          load_o  = 1'b1;
          instr_o = prog_data_i;
          if (cnt_q == LAST) begin
            prog_done_o = 1'b1;
            cnt_d       = '0;
            state_d     = SEQ_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = SEQ_IDLE;
    endcase
  end

  assign busy_o = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_shader_sequencer.sv
// Self-checking bench for shader_sequencer at depths 8 and 10, each paired with a
// behavioural circular instruction memory so alignment and program order are observable.
module tb_shader_sequencer;
  import shader_pkg::*;

  localparam int NA = 8;
  localparam int NB = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 0, req_a = 0, valid_a = 0;
  logic [7:0] data_a = '0;
  logic       ready_a, done_a, shift_a, load_a, exec_a, pdone_a, busy_a, miss_a;
  logic [7:0] instr_a;
  logic [2:0] pc_a;

  logic       start_b = 0, req_b = 0, valid_b = 0;
  logic [7:0] data_b = '0;
  logic       ready_b, done_b, shift_b, load_b, exec_b, pdone_b, busy_b, miss_b;
  logic [7:0] instr_b;
  logic [3:0] pc_b;

  shader_sequencer #(.NUM_INSTR(NA)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .prog_req_i(req_a),
    .prog_valid_i(valid_a), .prog_data_i(data_a), .prog_ready_o(ready_a),
    .prog_done_o(done_a), .shift_o(shift_a), .load_o(load_a), .instr_o(instr_a),
    .exec_valid_o(exec_a), .pc_o(pc_a), .pixel_done_o(pdone_a), .busy_o(busy_a),
    .start_miss_o(miss_a)
  );

  shader_sequencer #(.NUM_INSTR(NB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .prog_req_i(req_b),
    .prog_valid_i(valid_b), .prog_data_i(data_b), .prog_ready_o(ready_b),
    .prog_done_o(done_b), .shift_o(shift_b), .load_o(load_b), .instr_o(instr_b),
    .exec_valid_o(exec_b), .pc_o(pc_b), .pixel_done_o(pdone_b), .busy_o(busy_b),
    .start_miss_o(miss_b)
  );

  // Circular memories: output is slot 0, a shift rotates toward 0 and refills the top.
  logic [7:0] mem_a [NA];
  logic [7:0] mem_b [NB];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NA; i++) mem_a[i] <= default_instr(i);
    end else if (shift_a) begin
      for (int unsigned i = 0; i < NA - 1; i++) mem_a[i] <= mem_a[i+1];
      mem_a[NA-1] <= load_a ? instr_a : mem_a[0];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB; i++) mem_b[i] <= default_instr(i);
    end else if (shift_b) begin
      for (int unsigned i = 0; i < NB - 1; i++) mem_b[i] <= mem_b[i+1];
      mem_b[NB-1] <= load_b ? instr_b : mem_b[0];
    end
  end

  int total = 0;
  int bad = 0;
  logic [7:0] prog_a [NA];
  logic [7:0] load_bytes [NA];

  // {exec_valid, shift, load, pixel_done, start_miss, prog_ready, prog_done, busy}
  function automatic logic [7:0] flags_a();
    return {exec_a, shift_a, load_a, pdone_a, miss_a, ready_a, done_a, busy_a};
  endfunction

  task automatic kick();
    start_a = 1'b1;
    @(negedge clk);
    total++;
    if (flags_a() !== 8'b0) begin
      bad++;
      $display("FAIL kick_idle_flags got=%b want=%b", flags_a(), 8'b0);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic run_pixel(input int miss_at, input bit chain);
    logic [7:0] exp;
    for (int i = 0; i < NA; i++) begin
      start_a = (i == miss_at) || (chain && i == NA - 1);
      @(negedge clk);
      exp = {1'b1, 1'b1, 1'b0, (i == NA - 1), (i == miss_at), 1'b0, 1'b0, 1'b1};
      total++;
      if (flags_a() !== exp) begin
        bad++;
        $display("FAIL run_flags i=%0d got=%b want=%b", i, flags_a(), exp);
      end
      total++;
      if (pc_a !== 3'(i)) begin
        bad++;
        $display("FAIL run_pc i=%0d got=%0d want=%0d", i, pc_a, i);
      end
      total++;
      if (mem_a[0] !== prog_a[i]) begin
        bad++;
        $display("FAIL run_instr i=%0d got=%h want=%h", i, mem_a[0], prog_a[i]);
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    if (!chain) begin
      @(negedge clk);
      total++;
      if (flags_a() !== 8'b0) begin
        bad++;
        $display("FAIL run_tail_flags got=%b want=%b", flags_a(), 8'b0);
      end
      total++;
      if (mem_a[0] !== prog_a[0]) begin
        bad++;
        $display("FAIL run_tail_align got=%h want=%h", mem_a[0], prog_a[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic req_load();
    req_a = 1'b1;
    @(negedge clk);
    total++;
    if (flags_a() !== 8'b0) begin
      bad++;
      $display("FAIL req_idle_flags got=%b want=%b", flags_a(), 8'b0);
    end
    @(posedge clk); #1;
  endtask

  // Called on the first LOAD cycle; streams load_bytes with random valid gaps.
  task automatic load_prog(input int miss_cycle);
    int acc = 0;
    int cyc = 0;
    bit v, last;
    logic [7:0] exp, d;
    while (acc < NA && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      d = load_bytes[acc];
      last = v && (acc == NA - 1);
      valid_a = v;
      data_a  = v ? d : 8'($urandom);
      start_a = (cyc == miss_cycle);
      req_a   = last ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = {1'b0, v, v, 1'b0, (cyc == miss_cycle), 1'b1, last, 1'b1};
      total++;
      if (flags_a() !== exp) begin
        bad++;
        $display("FAIL load_flags cyc=%0d got=%b want=%b", cyc, flags_a(), exp);
      end
      total++;
      if (instr_a !== (v ? d : 8'h00)) begin
        bad++;
        $display("FAIL load_instr cyc=%0d got=%h want=%h", cyc, instr_a, v ? d : 8'h00);
      end
      @(posedge clk); #1;
      if (v) acc++;
      cyc++;
    end
    valid_a = 1'b0; start_a = 1'b0; req_a = 1'b0;
    total++;
    if (acc < NA) begin
      bad++;
      $display("FAIL load_timeout got=%0d want=%0d", acc, NA);
    end
    for (int i = 0; i < NA; i++) prog_a[i] = load_bytes[i];
    @(negedge clk);
    total++;
    if (flags_a() !== 8'b0) begin
      bad++;
      $display("FAIL load_end_flags got=%b want=%b", flags_a(), 8'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (flags_a() !== 8'b0 || instr_a !== 8'h00 || pc_a !== 3'd0) begin
      bad++;
      $display("FAIL reset_a got=%b/%h/%0d want=0", flags_a(), instr_a, pc_a);
    end
    total++;
    if ({exec_b, shift_b, load_b, busy_b, ready_b} !== 5'b0 || pc_b !== 4'd0) begin
      bad++;
      $display("FAIL reset_b got=%b/%0d want=0", {exec_b, shift_b, load_b, busy_b, ready_b}, pc_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NA; i++) prog_a[i] = default_instr(i);
  endtask

  task automatic test_single_pixel();
    kick();
    run_pixel(-1, 1'b0);
  endtask

  task automatic test_back_to_back();
    kick();
    run_pixel(-1, 1'b1);
    run_pixel(-1, 1'b0);
  endtask

  task automatic test_load_ordered();
    for (int i = 0; i < NA; i++) load_bytes[i] = 8'(i + 1);
    req_load();
    load_prog(-1);
    kick();
    run_pixel(-1, 1'b0);
  endtask

  task automatic test_load_random();
    for (int i = 0; i < NA; i++) load_bytes[i] = 8'($urandom);
    req_load();
    load_prog(int'($urandom_range(0, 6)));
    kick();
    run_pixel(int'($urandom_range(0, NA - 2)), 1'b0);
  endtask

  task automatic test_priority();
    for (int i = 0; i < NA; i++) load_bytes[i] = 8'($urandom);
    req_a = 1'b1;
    kick();
    run_pixel(3, 1'b0);
    load_prog(int'($urandom_range(0, 5)));
    kick();
    run_pixel(-1, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    req_load();
    req_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_a = 1'b1; data_a = 8'($urandom);
      @(posedge clk); #1;
    end
    data_a = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (flags_a() !== 8'b0 || instr_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_load got=%b/%h want=0/00", flags_a(), instr_a);
    end
    valid_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NA; i++) prog_a[i] = default_instr(i);
    kick();
    run_pixel(-1, 1'b0);
  endtask

  task automatic test_depth10();
    logic [7:0] bytes [NB];
    int acc = 0;
    int cyc = 0;
    bit v;
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
    req_b = 1'b1;
    @(posedge clk); #1;
    req_b = 1'b0;
    while (acc < NB && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      valid_b = v; data_b = bytes[acc];
      @(negedge clk);
      total++;
      if ({ready_b, load_b, shift_b, done_b} !== {1'b1, v, v, v && (acc == NB - 1)}) begin
        bad++;
        $display("FAIL d10_load cyc=%0d got=%b want=%b", cyc,
                 {ready_b, load_b, shift_b, done_b}, {1'b1, v, v, v && (acc == NB - 1)});
      end
      @(posedge clk); #1;
      if (v) acc++;
      cyc++;
    end
    valid_b = 1'b0;
    total++;
    if (acc < NB) begin
      bad++;
      $display("FAIL d10_load_timeout got=%0d want=%0d", acc, NB);
    end
    @(negedge clk);
    total++;
    if (busy_b !== 1'b0) begin
      bad++;
      $display("FAIL d10_load_end busy got=%b want=0", busy_b);
    end
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      total++;
      if ({exec_b, pdone_b} !== {1'b1, (i == NB - 1)} || pc_b !== 4'(i)) begin
        bad++;
        $display("FAIL d10_run i=%0d got=%b pc=%0d want=%b pc=%0d", i,
                 {exec_b, pdone_b}, pc_b, {1'b1, (i == NB - 1)}, i);
      end
      total++;
      if (mem_b[0] !== bytes[i]) begin
        bad++;
        $display("FAIL d10_instr i=%0d got=%h want=%h", i, mem_b[0], bytes[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (exec_b !== 1'b0 || busy_b !== 1'b0 || mem_b[0] !== bytes[0]) begin
      bad++;
      $display("FAIL d10_tail got=%b%b/%h want=00/%h", exec_b, busy_b, mem_b[0], bytes[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_load_ordered();
    test_load_random();
    test_priority();
    test_reset_mid_load();
    test_depth10();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
